sc_phase_sequencer: RTL and testbench

//  Generates the non-overlapping two-phase switch drives phi1/phi2 for the switched-capacitor filter from one system clock.

---
 rtl/sc_seq_pkg.sv | 18 +
 rtl/sc_phase_timer.sv | 37 +++
 rtl/sc_phase_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_sc_phase_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sc_seq_pkg.sv
// Shared types and default widths for the switched-capacitor phase sequencer.
// Contents: sc_state_t (sequencer FSM states), default counter widths.
// The INIT state exists in the enum for all builds; it is only reachable with SC_INIT_PRECHARGE_EN.
package sc_seq_pkg;

  localparam int CNT_W_DEF  = 8;   // phase-length / dead-time / burst counter width
  localparam int SCNT_W_DEF = 16;  // free-running sample counter width

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    P1,
    D12,
    P2,
    D21
  } sc_state_t;

endpackage

// File: rtl/sc_phase_timer.sv
// Loadable down-counter shared by all sequencer phases; done is high while the count is zero.
// Latency: load takes effect on the next clock edge; done is a decode of the registered count.
// Ports: clk, rst (async, active-high), load/load_val (reload request), done (count == 0).
module sc_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A state loaded with N-1 lasts exactly N clocks: the last one is where done is seen.
  assign done = (cnt_q == '0);

endmodule

// File: rtl/sc_phase_sequencer.sv
// Non-overlapping two-phase (phi1/phi2) switch-drive generator for the SC filter, with burst and sample flagging.
// Latency: phi1 rises on the first clock edge after en is sampled high; phi1/phi2 are registered.
// Flow: en is a level run request, honoured only in IDLE and at the end of D21; no backpressure.
// Ports: clk, rst (async, active-high), en, cfg_ph_len, cfg_dead, cfg_burst (latched at start),
//        phi1, phi2, busy, sample_valid (pulse on last P2 clock), sample_cnt (wrapping period count).
// Build option: SC_INIT_PRECHARGE_EN adds an INIT precharge phase (phi2 high INIT_LEN clocks, then dead, then P1).
module sc_phase_sequencer
  import sc_seq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SCNT_W = SCNT_W_DEF
`ifdef SC_INIT_PRECHARGE_EN
  ,
  parameter int INIT_LEN = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  cfg_ph_len,
  input  logic [CNT_W-1:0]  cfg_dead,
  input  logic [CNT_W-1:0]  cfg_burst,
  output logic              phi1,
  output logic              phi2,
  output logic              busy,
  output logic              sample_valid,
  output logic [SCNT_W-1:0] sample_cnt
);

  sc_state_t state_q, state_d;

  logic [CNT_W-1:0]  ph_len_q, ph_len_d;
  logic [CNT_W-1:0]  dead_q, dead_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [SCNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic              need_low_q, need_low_d;
  logic              phi1_q, phi1_d;
  logic              phi2_q, phi2_d;
`ifdef SC_INIT_PRECHARGE_EN
  logic              init_gap_q, init_gap_d;
`endif

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;
  logic              sample_pulse;

  // Timer reload values: a programmed length of 0 behaves like 1.
  logic [CNT_W-1:0]  ph_ld, dead_ld, cfg_ph_ld;
`ifdef SC_INIT_PRECHARGE_EN
  logic [CNT_W-1:0]  cfg_dead_ld;
  assign cfg_dead_ld = (cfg_dead == '0) ? '0 : cfg_dead - CNT_W'(1);
`endif
  assign ph_ld     = (ph_len_q == '0)   ? '0 : ph_len_q - CNT_W'(1);
  assign dead_ld   = (dead_q == '0)     ? '0 : dead_q - CNT_W'(1);
  assign cfg_ph_ld = (cfg_ph_len == '0) ? '0 : cfg_ph_len - CNT_W'(1);

  sc_phase_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    ph_len_d     = ph_len_q;
    dead_d       = dead_q;
    burst_d      = burst_q;
    burst_cnt_d  = burst_cnt_q;
    sample_cnt_d = sample_cnt_q;
    need_low_d   = need_low_q;
`ifdef SC_INIT_PRECHARGE_EN
    init_gap_d   = init_gap_q;
`endif
    tmr_load     = 1'b0;
    tmr_val      = '0;
    sample_pulse = 1'b0;

    case (state_q)
      IDLE: begin
        // need_low_q blocks an automatic restart after a finished burst while en is still held.
        if (en && !need_low_q) begin
          ph_len_d    = cfg_ph_len;
          dead_d      = cfg_dead;
          burst_d     = cfg_burst;
          burst_cnt_d = '0;
          tmr_load    = 1'b1;
`ifdef SC_INIT_PRECHARGE_EN
          state_d     = INIT;
          tmr_val     = CNT_W'(INIT_LEN - 1);
`else
          state_d     = P1;
          tmr_val     = cfg_ph_ld;
`endif
        end else if (!en) begin
          need_low_d = 1'b0;
        end
      end

      INIT: begin
`ifdef SC_INIT_PRECHARGE_EN
        // The post-precharge gap reuses D21; init_gap_q makes it fall through to P1 unconditionally.
        if (tmr_done) begin
          state_d    = D21;
          init_gap_d = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = dead_ld;
        end
`else
        state_d = IDLE;
`endif
      end

      P1: begin
        if (tmr_done) begin
          state_d  = D12;
          tmr_load = 1'b1;
          tmr_val  = dead_ld;
        end
      end

      D12: begin
        if (tmr_done) begin
          state_d  = P2;
          tmr_load = 1'b1;
          tmr_val  = ph_ld;
        end
      end

      P2: begin
        if (tmr_done) begin
          sample_pulse = 1'b1;
          sample_cnt_d = sample_cnt_q + SCNT_W'(1);
          if (burst_q != '0) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
          state_d  = D21;
          tmr_load = 1'b1;
          tmr_val  = dead_ld;
        end
      end

      D21: begin
        if (tmr_done) begin
`ifdef SC_INIT_PRECHARGE_EN
          if (init_gap_q) begin
            init_gap_d = 1'b0;
            state_d    = P1;
            tmr_load   = 1'b1;
            tmr_val    = ph_ld;
          end else
`endif
          if (en && ((burst_q == '0) || (burst_cnt_q != burst_q))) begin
            state_d  = P1;
            tmr_load = 1'b1;
            tmr_val  = ph_ld;
          end else begin
            // Leaving with en still high means the burst ran out: require en low before the next start.
            state_d    = IDLE;
            need_low_d = en;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Drives decode from the next state so the registered outputs line up with state_q.
    phi1_d = (state_d == P1);
    phi2_d = (state_d == P2) || (state_d == INIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ph_len_q     <= '0;
      dead_q       <= '0;
      burst_q      <= '0;
      burst_cnt_q  <= '0;
      sample_cnt_q <= '0;
      need_low_q   <= 1'b0;
      phi1_q       <= 1'b0;
      phi2_q       <= 1'b0;
`ifdef SC_INIT_PRECHARGE_EN
      init_gap_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ph_len_q     <= ph_len_d;
      dead_q       <= dead_d;
      burst_q      <= burst_d;
      burst_cnt_q  <= burst_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      need_low_q   <= need_low_d;
      phi1_q       <= phi1_d;
      phi2_q       <= phi2_d;
`ifdef SC_INIT_PRECHARGE_EN
      init_gap_q   <= init_gap_d;
`endif
    end
  end

  assign phi1         = phi1_q;
  assign phi2         = phi2_q;
  assign busy         = (state_q != IDLE);
  assign sample_valid = sample_pulse;
  assign sample_cnt   = sample_cnt_q;

endmodule

// File: tb/tb_sc_phase_sequencer.sv
// Directed bench for sc_phase_sequencer (default build): per-cycle waveform checks against
// the closed-form period pattern, plus burst re-arm, graceful stop and async reset sequences.
module tb_sc_phase_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  cfg_ph_len;
  logic [7:0]  cfg_dead;
  logic [7:0]  cfg_burst;
  logic        phi1;
  logic        phi2;
  logic        busy;
  logic        sample_valid;
  logic [15:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  sc_phase_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_ph_len   (cfg_ph_len),
    .cfg_dead     (cfg_dead),
    .cfg_burst    (cfg_burst),
    .phi1         (phi1),
    .phi2         (phi2),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_cnt   (sample_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phases never overlap, and each phase is followed by at least one clock with the other low.
  a_excl: assert property (@(posedge clk) !(phi1 && phi2));
  a_gap12: assert property (@(posedge clk) disable iff (rst) phi1 |=> !phi2);
  a_gap21: assert property (@(posedge clk) disable iff (rst) phi2 |=> !phi1);

  typedef struct {
    int ph_len;
    int dead;
    int burst;
    int ncyc;
    int exp_period;
    int exp_pulses;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'({phi1, phi2, sample_valid, busy, sample_cnt}), 32'h0);
    rst = 1'b0;
  endtask

  // Starts a run with en=1 and checks every clock against the period formula.
  // k=0 is the first clock after the starting edge; periods beyond the burst or the
  // period in which en was dropped (stop_k) must be idle.
  task automatic run_vec(input string nm, input int l_cfg, input int d_cfg, input int b,
                         input int n, input int p, input int stop_k,
                         input int base_cnt, input int exp_pulses);
    int l;
    int d;
    int lim;
    int cnt;
    int pulses;
    int per;
    int pos;
    logic act;
    logic e_phi1, e_phi2, e_sv;
    l   = (l_cfg == 0) ? 1 : l_cfg;
    d   = (d_cfg == 0) ? 1 : d_cfg;
    lim = b;
    if (stop_k >= 0) begin
      if (lim == 0 || (stop_k / p + 1) < lim) lim = stop_k / p + 1;
    end
    @(negedge clk);
    cfg_ph_len = 8'(l_cfg);
    cfg_dead   = 8'(d_cfg);
    cfg_burst  = 8'(b);
    en         = 1'b1;
    @(posedge clk);
    cnt    = base_cnt;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      per    = k / p;
      pos    = k % p;
      act    = (lim == 0) || (per < lim);
      e_phi1 = act && (pos < l);
      e_phi2 = act && (pos >= l + d) && (pos < 2 * l + d);
      e_sv   = act && (pos == 2 * l + d - 1);
      chk(nm, 32'({phi1, phi2, sample_valid, busy, sample_cnt}),
          32'({e_phi1, e_phi2, e_sv, act, 16'(cnt)}));
      if (sample_valid) pulses++;
      if (e_sv) cnt++;
      if (k == stop_k) en = 1'b0;
    end
    chk({nm, "_pulses"}, 32'(pulses), 32'(exp_pulses));
    @(negedge clk);
    chk({nm, "_cnt"}, 32'(sample_cnt), 32'(base_cnt + exp_pulses));
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b0;
    cfg_ph_len = '0;
    cfg_dead   = '0;
    cfg_burst  = '0;

    //             ph_len dead burst ncyc period pulses
    vecs[0] = '{4,     2,   0,    100, 12,    8};
    vecs[1] = '{0,     0,   0,    40,  4,     10};
    vecs[2] = '{1,     3,   2,    20,  8,     2};
    vecs[3] = '{3,     1,   0,    30,  8,     3};
    vecs[4] = '{1,     1,   1,    8,   4,     1};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_vec($sformatf("vec%0d", i), vecs[i].ph_len, vecs[i].dead, vecs[i].burst,
              vecs[i].ncyc, vecs[i].exp_period, -1, 0, vecs[i].exp_pulses);
    end

    // Burst of 3 with en held: stops, stays idle, then re-arms after en low for one clock.
    do_reset();
    run_vec("burst_a", 2, 1, 3, 30, 6, -1, 0, 3);
    chk("burst_a_idle", 32'({busy, sample_cnt}), 32'({1'b0, 16'd3}));
    en = 1'b0;
    run_vec("burst_b", 2, 1, 3, 30, 6, -1, 3, 3);
    chk("burst_b_idle", 32'({busy, sample_cnt}), 32'({1'b0, 16'd6}));

    // en dropped during P1 of the second period: that period still completes.
    do_reset();
    run_vec("graceful", 4, 2, 0, 40, 12, 13, 0, 2);

    // Async reset in the middle of P2 of the second period.
    do_reset();
    run_vec("pre_areset", 4, 2, 0, 19, 12, -1, 0, 1);
    chk("pre_areset_phi2", 32'(phi2), 32'h1);
    #2 rst = 1'b1;
    #1 chk("areset_async", 32'({phi1, phi2, busy, sample_cnt}), 32'h0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_vec("post_areset", 4, 2, 0, 40, 12, -1, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
